// File: rtl/orb_pkg.sv
// Shared constants and types for the orbital-word frame path.
package orb_pkg;

   localparam int unsigned ORB_WORD_W   = 12;
   localparam int unsigned ORB_ADDR_W   = 11;
   localparam int unsigned ORB_MARK_BIT = ORB_WORD_W - 1;

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      RUN
   } orb_state_e;

endpackage

// File: rtl/orb_frame_reader_if.sv
// Read port of the ping-pong frame buffer, seen from the reader (master) and buffer (slave).
interface orb_frame_reader_if #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned WORD_W = 12
) ();

   logic              rdEn;
   logic [ADDR_W-1:0] rdAddr;
   logic [WORD_W-1:0] rdData;

   modport master (
      output rdEn,
      output rdAddr,
      input  rdData
   );

   modport slave (
      input  rdEn,
      input  rdAddr,
      output rdData
   );

endinterface

// File: rtl/orb_bit_timer.sv
// Bit-rate divider and bit index for the serial word shifter.
// Tick outputs name the action to take at the end of the current clk.
module orb_bit_timer #(
   parameter int unsigned WORD_W  = 12,
   parameter int unsigned BIT_DIV = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic start,
   output logic bit_strobe,
   output logic word_strobe,
   output logic end_tick,
   output logic load_tick,
   output logic pre_tick
);

   localparam int unsigned DIV_W = $clog2(BIT_DIV);
   localparam int unsigned IDX_W = $clog2(WORD_W);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(WORD_W - 1);
   // Prefetch is issued on the edge that enters bit index WORD_W/2.
   localparam logic [IDX_W-1:0] IDX_PRE  = IDX_W'(WORD_W / 2 + 1);

   logic [DIV_W-1:0] div_cnt_q;
   logic [IDX_W-1:0] bit_idx_q;

   // Divider counts BIT_DIV clks per bit; bit index walks WORD_W-1 down to 0 and wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_q <= '0;
         bit_idx_q <= '0;
      end else if (start) begin
         div_cnt_q <= '0;
         bit_idx_q <= IDX_TOP;
      end else if (run) begin
         if (div_cnt_q == DIV_LAST) begin
            div_cnt_q <= '0;
            bit_idx_q <= (bit_idx_q == '0) ? IDX_TOP : bit_idx_q - IDX_W'(1);
         end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
         end
      end else begin
         div_cnt_q <= '0;
         bit_idx_q <= '0;
      end
   end

   // Strobes for the current bit and ticks for the upcoming edge.
   always_comb begin
      bit_strobe  = run && (div_cnt_q == '0);
      word_strobe = bit_strobe && (bit_idx_q == IDX_TOP);
      end_tick    = run && (div_cnt_q == DIV_LAST);
      load_tick   = end_tick && (bit_idx_q == '0);
      pre_tick    = end_tick && (bit_idx_q == IDX_PRE);
   end

endmodule

// File: rtl/orb_frame_reader.sv
// Sweeps the frame buffer one word per word slot and streams each word MSB-first,
// toggling the buffer-select level SW at every frame boundary after the first.
module orb_frame_reader
   import orb_pkg::*;
#(
   parameter int unsigned ADDR_W  = ORB_ADDR_W,
   parameter int unsigned WORD_W  = ORB_WORD_W,
   parameter int unsigned BIT_DIV = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   orb_frame_reader_if.master rd,
   output logic               serOut,
   output logic               bitStrobe,
   output logic               wordStart,
   output logic               frameStart,
   output logic               SW
);

   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   orb_state_e        state_q, state_d;
   logic [ADDR_W-1:0] wrd_cnt_q, new_wrd;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              rd_en_q, rd_en_d;
   logic              cap_q;
   logic [WORD_W-1:0] next_word_q, shift_q;
   logic [WORD_W-1:0] load_src, load_word;
   logic              sw_q;
   logic              start, load, stop, toggle_sw;
   logic              bit_strobe, word_strobe, end_tick, load_tick, pre_tick;

   orb_bit_timer #(
      .WORD_W  (WORD_W),
      .BIT_DIV (BIT_DIV)
   ) u_bit_timer (
      .clk         (clk),
      .rst         (rst),
      .run         (state_q == RUN),
      .start       (start),
      .bit_strobe  (bit_strobe),
      .word_strobe (word_strobe),
      .end_tick    (end_tick),
      .load_tick   (load_tick),
      .pre_tick    (pre_tick)
   );

   // Next state, read requests and word-load decisions.
   always_comb begin
      state_d   = state_q;
      start     = 1'b0;
      load      = 1'b0;
      stop      = 1'b0;
      toggle_sw = 1'b0;
      rd_en_d   = 1'b0;
      rd_addr_d = wrd_cnt_q + ADDR_W'(1);
      unique case (state_q)
         IDLE: begin
            if (en) begin
               state_d   = PRIME;
               rd_en_d   = 1'b1;
               rd_addr_d = '0;
            end
         end
         PRIME: begin
            // Word 0 data is on rdData while cap_q is set.
            if (cap_q) begin
               state_d = RUN;
               start   = 1'b1;
            end
         end
         RUN: begin
            rd_en_d = pre_tick;
            if (load_tick) begin
               if (wrd_cnt_q != ADDR_LAST) begin
                  load = 1'b1;
               end else if (en) begin
                  load      = 1'b1;
                  toggle_sw = 1'b1;
               end else begin
                  stop    = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Word to load into the shifter, with the marker bit set only on word 0.
   always_comb begin
      new_wrd   = start ? '0 : wrd_cnt_q + ADDR_W'(1);
      // The first load after PRIME takes rdData directly, as it is captured the same clk.
      load_src  = start ? rd.rdData : next_word_q;
      load_word = load_src;
      load_word[WORD_W-1] = (new_wrd == '0);
   end

   // State, read port, next-word register, shifter and buffer select.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         cap_q       <= 1'b0;
         next_word_q <= '0;
         shift_q     <= '0;
         wrd_cnt_q   <= '0;
         sw_q        <= 1'b0;
      end else begin
         state_q <= state_d;
         rd_en_q <= rd_en_d;
         if (rd_en_d) begin
            rd_addr_q <= rd_addr_d;
         end
         cap_q <= rd_en_q;
         if (cap_q) begin
            next_word_q <= rd.rdData;
         end
         if (start || load) begin
            shift_q   <= load_word;
            wrd_cnt_q <= new_wrd;
         end else if (stop) begin
            shift_q   <= '0;
            wrd_cnt_q <= '0;
         end else if (end_tick) begin
            shift_q <= {shift_q[WORD_W-2:0], 1'b0};
         end
         if (toggle_sw) begin
            sw_q <= ~sw_q;
         end
      end
   end

   assign rd.rdEn    = rd_en_q;
   assign rd.rdAddr  = rd_addr_q;
   assign serOut     = shift_q[WORD_W-1];
   assign bitStrobe  = bit_strobe;
   assign wordStart  = word_strobe;
   assign frameStart = word_strobe && (wrd_cnt_q == '0);
   assign SW         = sw_q;

endmodule
